// File: rtl/pipe_pkg.sv
// Shared definitions for P8 pipeline-stage registers.
// Occupancy codes and default MEM/WB payload widths.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int CTRL_W_MEMWB = 5;
    localparam int DATA_W_MEMWB = 165;

    function automatic logic [1:0] occ_of(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline-stage entry: valid bit, control field, data field.
// Clear wins over load; data is only wiped when zero_data_i is set.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              zero_data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge CLK) begin
        if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (zero_data_i) begin
                data_q <= '0;
            end
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with one-entry skid buffer, flush
// and a saturating stall-cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16,
    parameter bit ZERO_DATA = 1'b1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              main_load;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clr;
    logic              zero_d;
    logic              accept;
    logic              drain;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        zero_d         = 1'b0;
        if (reset || flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            zero_d   = ZERO_DATA;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .CLK         (CLK),
        .load_i      (main_load),
        .clear_i     (main_clr),
        .zero_data_i (zero_d),
        .ctrl_i      (main_ctrl_in),
        .data_i      (main_data_in),
        .valid_o     (main_valid),
        .ctrl_o      (main_ctrl),
        .data_o      (main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .CLK         (CLK),
        .load_i      (skid_load),
        .clear_i     (skid_clr),
        .zero_data_i (zero_d),
        .ctrl_i      (in_ctrl),
        .data_i      (in_data),
        .valid_o     (skid_valid),
        .ctrl_o      (skid_ctrl),
        .data_o      (skid_data)
    );

    // Counts blocked cycles regardless of flush; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (reset) begin
            stall_d = '0;
        end else if (main_valid && !out_ready && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        stall_q <= stall_d;
    end

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = occ_of(main_valid, skid_valid);
    assign stall_cnt = stall_q;

endmodule
